mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 24, SHALL set the number of significant address bits; s_addr bits above ADDR_WIDTH-1 SHALL be driven 0.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 mX_addr  input  32  master X request address (X = 0, 1; 0 = CPU, 1 = DMA/debug).
REQ-005 mX_wdata  input  32  master X write data.
REQ-006 mX_wmask  input  4  master X byte write mask; nonzero for one cycle issues a write.
REQ-007 mX_rstrb  input  1  master X one-cycle read strobe.
REQ-008 mX_rdata  output  32  master X captured read data.
REQ-009 mX_rbusy / mX_wbusy  output  1 each  master X read / write outstanding.
REQ-010 s_addr, s_wdata  output  32 each  shared-memory address and write data.
REQ-011 s_wmask  output  4; s_rstrb  output  1  shared-memory write mask and read strobe.
REQ-012 s_rdata  input  32; s_rbusy, s_wbusy  input  1 each  shared-memory read data and busy flags.
REQ-013 grant  output  1  index of the master currently owning the slave (valid outside IDLE).

Function
REQ-014 Each master SHALL have a pending flag, kind bit (read/write) and latched addr/wdata/wmask, captured on the cycle mX_rstrb=1 or |mX_wmask=1.
REQ-015 If mX_rstrb and |mX_wmask are asserted together, the request SHALL be taken as a write.
REQ-016 A new request from master X while its pending flag is set SHALL be ignored; latched fields SHALL NOT change.
REQ-017 mX_rbusy SHALL equal pending & read-kind, and mX_wbusy SHALL equal pending & write-kind, both registered (high the cycle after the strobe).
REQ-018 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-019 IDLE: if any pending flag is set, the FSM SHALL select a winner and enter ISSUE on the next edge; otherwise it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: with both pending, the master not granted last wins; with one pending, that master wins.
REQ-021 ISSUE lasts exactly one cycle: s_rstrb=1 for a read, or s_wmask=latched wmask for a write; then the FSM SHALL enter WAIT.
REQ-022 s_addr/s_wdata SHALL present the granted master's latched values in ISSUE and WAIT; s_rstrb=0 and s_wmask=0 in every state other than ISSUE.
REQ-023 WAIT: a read SHALL complete on the first cycle s_rbusy=0, and a write on the first cycle s_wbusy=0; otherwise the FSM SHALL remain in WAIT indefinitely.
REQ-024 On completion the FSM SHALL capture s_rdata into mX_rdata (reads only), clear pending X, and return to IDLE; busy SHALL fall on the next cycle.
REQ-025 mX_rdata SHALL hold its value until the next completed read of master X; writes SHALL NOT alter it.
REQ-026 Zero-wait latency SHALL be: strobe at cycle N; busy high N+1..N+3; s_rstrb at N+2; rdata valid and busy low at N+4.
REQ-027 A strobe from the other master during ISSUE/WAIT SHALL be latched and served after the current transfer, with no lost request.
REQ-028 Completion for master X and a new strobe from master X in the same cycle: the clear SHALL win, and the strobe SHALL be ignored (REQ-016).

Reset
REQ-029 reset=0 SHALL force state=IDLE, both pending flags=0, all busy outputs=0, mX_rdata=0, s_rstrb=0, s_wmask=0, s_addr=0, s_wdata=0, and last-grant=1 so master 0 wins the first tie.
REQ-030 Reset asserted mid-transfer SHALL abort it, with no completion, no rdata capture, and every output at its reset value on the next edge.

Verification
REQ-031 Single read: m0_rstrb, addr=0x100, zero-wait slave returns 0xDEADBEEF -> s_rstrb at N+2, m0_rbusy high N+1..N+3, m0_rdata=0xDEADBEEF at N+4.
REQ-032 Simultaneous requests: m0 read and m1 write (wmask=4'b0011) in the same cycle after reset -> m0 served first, then m1; the next tie goes to m0 again.
REQ-033 Slow write: m1 write with s_wbusy held high 5 cycles -> s_wmask for exactly one cycle, m1_wbusy high until the cycle after s_wbusy falls.
REQ-034 Back-to-back: m1 strobes during m0's WAIT -> m1 issued immediately after m0 returns to IDLE (IDLE held one cycle), and no request is dropped.
REQ-035 Protocol violation: a second m0_rstrb while m0_rbusy=1 with a different addr -> ignored, and the original address is completed.
REQ-036 Reset during WAIT: reset=0 for one cycle -> all busy outputs 0, rdata 0, FSM in IDLE, and no s_rstrb is reissued.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the shared memory port.
// The arbiter uses the slave modport; the surrounding system uses the master modport.
interface mem_bus_arbiter_if;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wmask;
  logic        m0_rstrb, m0_rbusy, m0_wbusy;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wmask;
  logic        m1_rstrb, m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb, s_rbusy, s_wbusy;
  logic        grant;

  modport slave (
    input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    input  m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    input  s_rdata, s_rbusy, s_wbusy,
    output m0_rdata, m0_rbusy, m0_wbusy,
    output m1_rdata, m1_rbusy, m1_wbusy,
    output s_addr, s_wdata, s_wmask, s_rstrb, grant
  );

  modport master (
    output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    output m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    output s_rdata, s_rbusy, s_wbusy,
    input  m0_rdata, m0_rbusy, m0_wbusy,
    input  m1_rdata, m1_rbusy, m1_wbusy,
    input  s_addr, s_wdata, s_wmask, s_rstrb, grant
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of one shared memory port.
// Each master owns a one-deep request latch; the FSM serves one transfer at a time.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam logic [31:0] ADDR_MASK = 32'hFFFF_FFFF >> (32 - ADDR_WIDTH);

  state_e      state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  kind_q, kind_d;
  logic        grant_q, grant_d;
  logic [31:0] addr_q [2];
  logic [31:0] addr_d [2];
  logic [31:0] wdata_q [2];
  logic [31:0] wdata_d [2];
  logic [3:0]  wmask_q [2];
  logic [3:0]  wmask_d [2];
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];
  logic [31:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [3:0]  s_wmask_q, s_wmask_d;
  logic        s_rstrb_q, s_rstrb_d;

  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wmask [2];
  logic [1:0]  m_rstrb;
  logic        winner, done;

  assign m_addr[0]  = bus.m0_addr;
  assign m_addr[1]  = bus.m1_addr;
  assign m_wdata[0] = bus.m0_wdata;
  assign m_wdata[1] = bus.m1_wdata;
  assign m_wmask[0] = bus.m0_wmask;
  assign m_wmask[1] = bus.m1_wmask;
  assign m_rstrb    = {bus.m1_rstrb, bus.m0_rstrb};

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    kind_d    = kind_q;
    grant_d   = grant_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    rdata_d   = rdata_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wmask_d = 4'b0;
    s_rstrb_d = 1'b0;

    // A busy master's strobe is dropped, so a completion clear below always wins.
    for (int i = 0; i < 2; i++) begin
      if (!pend_q[i] && (m_rstrb[i] || (|m_wmask[i]))) begin
        pend_d[i]  = 1'b1;
        kind_d[i]  = |m_wmask[i];
        addr_d[i]  = m_addr[i] & ADDR_MASK;
        wdata_d[i] = m_wdata[i];
        wmask_d[i] = m_wmask[i];
      end
    end

    winner = (pend_q == 2'b11) ? ~grant_q : pend_q[1];
    done   = kind_q[grant_q] ? !bus.s_wbusy : !bus.s_rbusy;

    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          state_d   = ISSUE;
          grant_d   = winner;
          s_addr_d  = addr_q[winner];
          s_wdata_d = wdata_q[winner];
          if (kind_q[winner]) s_wmask_d = wmask_q[winner];
          else                s_rstrb_d = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (done) begin
          state_d         = IDLE;
          pend_d[grant_q] = 1'b0;
          if (!kind_q[grant_q]) rdata_d[grant_q] = bus.s_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pend_q    <= 2'b00;
      kind_q    <= 2'b00;
      grant_q   <= 1'b1;
      rdata_q   <= '{default: 32'h0};
      s_addr_q  <= 32'h0;
      s_wdata_q <= 32'h0;
      s_wmask_q <= 4'b0;
      s_rstrb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      kind_q    <= kind_d;
      grant_q   <= grant_d;
      rdata_q   <= rdata_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wmask_q <= s_wmask_d;
      s_rstrb_q <= s_rstrb_d;
    end
  end

  // Latched request fields are only read while their pending flag is set.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wmask_q <= wmask_d;
  end

  assign bus.m0_rbusy = pend_q[0] & ~kind_q[0];
  assign bus.m0_wbusy = pend_q[0] &  kind_q[0];
  assign bus.m1_rbusy = pend_q[1] & ~kind_q[1];
  assign bus.m1_wbusy = pend_q[1] &  kind_q[1];
  assign bus.m0_rdata = rdata_q[0];
  assign bus.m1_rdata = rdata_q[1];
  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_wmask  = s_wmask_q;
  assign bus.s_rstrb  = s_rstrb_q;
  assign bus.grant    = grant_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table plus hand sequences, slave-side issues
// checked against a scoreboard of expected transfers.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();
  mem_bus_arbiter #(.ADDR_WIDTH(24)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          m;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          w;
    logic [31:0] exp_saddr;
    logic        exp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        rstrb;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } sb_t;

  sb_t  sb_q[$];
  sb_t  mon_e;
  vec_t vecs[7];
  int   checks = 0, errors = 0;
  int   cyc = 0, last_issue_cyc = -1;
  int   slow = 0, scnt = 0;
  int   n;

  always @(posedge clk) cyc++;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign bus.s_rdata = rd_model(bus.s_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave model and issue monitor: busy stays high for 'slow' sampled WAIT cycles.
  always @(negedge clk) begin
    if (bus.s_rstrb === 1'b1 || (|bus.s_wmask) === 1'b1) begin
      last_issue_cyc = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: addr %h rstrb %b wmask %b, expected no transfer", bus.s_addr, bus.s_rstrb, bus.s_wmask);
      end else begin
        mon_e = sb_q.pop_front();
        chk("issue_grant", 32'(bus.grant), 32'(mon_e.m));
        chk("issue_addr", bus.s_addr, mon_e.addr);
        chk("issue_rstrb", 32'(bus.s_rstrb), 32'(mon_e.rstrb));
        chk("issue_wmask", 32'(bus.s_wmask), 32'(mon_e.wmask));
        if (mon_e.wmask != 4'b0) chk("issue_wdata", bus.s_wdata, mon_e.wdata);
      end
      scnt = (slow == 0) ? 0 : slow + 1;
    end else if (scnt > 0) begin
      scnt--;
    end
    bus.s_rbusy = (scnt > 0);
    bus.s_wbusy = (scnt > 0);
  end

  task automatic drive(input int m, input logic rs, input logic [3:0] wm,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_rstrb = rs; bus.m0_wmask = wm; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_rstrb = rs; bus.m1_wmask = wm; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  task automatic push(input int m, input logic [31:0] a, input logic rs,
                      input logic [3:0] wm, input logic [31:0] d);
    sb_t e;
    e.m = m; e.addr = a; e.rstrb = rs; e.wmask = wm; e.wdata = d;
    sb_q.push_back(e);
  endtask

  function automatic logic rbusy_of(input int m);
    return (m == 0) ? bus.m0_rbusy : bus.m1_rbusy;
  endfunction
  function automatic logic wbusy_of(input int m);
    return (m == 0) ? bus.m0_wbusy : bus.m1_wbusy;
  endfunction
  function automatic logic [31:0] rdata_of(input int m);
    return (m == 0) ? bus.m0_rdata : bus.m1_rdata;
  endfunction

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int n0;
    n0   = cyc;
    slow = v.w;
    drive(v.m, v.rstrb, v.wmask, v.addr, v.wdata);
    push(v.m, v.exp_saddr, !v.exp_wr, v.exp_wr ? v.wmask : 4'b0, v.wdata);
    step(1);
    drive(v.m, 1'b0, 4'b0, v.addr, v.wdata);
    chk("vec_rbusy_n1", 32'(rbusy_of(v.m)), 32'(!v.exp_wr));
    chk("vec_wbusy_n1", 32'(wbusy_of(v.m)), 32'(v.exp_wr));
    for (int c = 2; c <= 3 + v.w; c++) begin
      step(1);
      chk("vec_busy_held", 32'(rbusy_of(v.m) | wbusy_of(v.m)), 32'd1);
    end
    step(1);
    chk("vec_busy_done", 32'(rbusy_of(v.m) | wbusy_of(v.m)), 32'd0);
    chk("vec_rdata", rdata_of(v.m), v.exp_rdata);
    chk("vec_issue_cycle", 32'(last_issue_cyc), 32'(n0 + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{m:0, rstrb:1'b1, wmask:4'h0, addr:32'h0000_0100, wdata:32'h0, w:0,
                exp_saddr:32'h0000_0100, exp_wr:1'b0, exp_rdata:32'hDEADBEEF};
    vecs[1] = '{m:1, rstrb:1'b1, wmask:4'h0, addr:32'h0000_0200, wdata:32'h0, w:0,
                exp_saddr:32'h0000_0200, exp_wr:1'b0, exp_rdata:32'h0200_FDFF};
    vecs[2] = '{m:0, rstrb:1'b0, wmask:4'hF, addr:32'h0000_0300, wdata:32'h1122_3344, w:0,
                exp_saddr:32'h0000_0300, exp_wr:1'b1, exp_rdata:32'hDEADBEEF};
    vecs[3] = '{m:1, rstrb:1'b0, wmask:4'h3, addr:32'h0000_0500, wdata:32'hCAFE_0002, w:5,
                exp_saddr:32'h0000_0500, exp_wr:1'b1, exp_rdata:32'h0200_FDFF};
    vecs[4] = '{m:0, rstrb:1'b1, wmask:4'h0, addr:32'hFF12_3456, wdata:32'h0, w:2,
                exp_saddr:32'h0012_3456, exp_wr:1'b0, exp_rdata:32'h3456_CBA9};
    vecs[5] = '{m:0, rstrb:1'b1, wmask:4'h8, addr:32'h0000_0040, wdata:32'hA5A5_A5A5, w:1,
                exp_saddr:32'h0000_0040, exp_wr:1'b1, exp_rdata:32'h3456_CBA9};
    vecs[6] = '{m:1, rstrb:1'b1, wmask:4'h0, addr:32'h0000_1234, wdata:32'h0, w:3,
                exp_saddr:32'h0000_1234, exp_wr:1'b0, exp_rdata:32'h1234_EDCB};

    reset = 1'b0;
    drive(0, 1'b0, 4'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 4'b0, 32'h0, 32'h0);
    step(3);
    chk("rst_m0_rbusy", 32'(bus.m0_rbusy), 32'd0);
    chk("rst_m0_wbusy", 32'(bus.m0_wbusy), 32'd0);
    chk("rst_m1_rbusy", 32'(bus.m1_rbusy), 32'd0);
    chk("rst_m1_wbusy", 32'(bus.m1_wbusy), 32'd0);
    chk("rst_m0_rdata", bus.m0_rdata, 32'h0);
    chk("rst_m1_rdata", bus.m1_rdata, 32'h0);
    chk("rst_s_rstrb", 32'(bus.s_rstrb), 32'd0);
    chk("rst_s_wmask", 32'(bus.s_wmask), 32'd0);
    chk("rst_s_addr", bus.s_addr, 32'h0);
    chk("rst_s_wdata", bus.s_wdata, 32'h0);
    reset = 1'b1;
    step(1);

    // Simultaneous requests right after reset: m0 first, then m1.
    n = cyc;
    slow = 0;
    drive(0, 1'b1, 4'b0, 32'h100, 32'h0);
    drive(1, 1'b0, 4'b0011, 32'h500, 32'hCAFE_0001);
    push(0, 32'h100, 1'b1, 4'b0, 32'h0);
    push(1, 32'h500, 1'b0, 4'b0011, 32'hCAFE_0001);
    step(1);
    drive(0, 1'b0, 4'b0, 32'h100, 32'h0);
    drive(1, 1'b0, 4'b0, 32'h500, 32'h0);
    chk("tie_m0_rbusy", 32'(bus.m0_rbusy), 32'd1);
    chk("tie_m1_wbusy", 32'(bus.m1_wbusy), 32'd1);
    step(3);
    chk("tie_m0_done", 32'(bus.m0_rbusy), 32'd0);
    chk("tie_m0_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk("tie_m1_waiting", 32'(bus.m1_wbusy), 32'd1);
    step(3);
    chk("tie_m1_done", 32'(bus.m1_wbusy), 32'd0);
    chk("tie_m1_issue_cycle", 32'(last_issue_cyc), 32'(n + 5));

    // Second tie: m1 was granted last, so m0 wins again.
    drive(0, 1'b1, 4'b0, 32'h204, 32'h0);
    drive(1, 1'b1, 4'b0, 32'h208, 32'h0);
    push(0, 32'h204, 1'b1, 4'b0, 32'h0);
    push(1, 32'h208, 1'b1, 4'b0, 32'h0);
    step(1);
    drive(0, 1'b0, 4'b0, 32'h204, 32'h0);
    drive(1, 1'b0, 4'b0, 32'h208, 32'h0);
    step(6);
    chk("tie2_m0_rdata", bus.m0_rdata, 32'h0204_FDFB);
    chk("tie2_m1_rdata", bus.m1_rdata, 32'h0208_FDF7);
    chk("tie2_idle", 32'({bus.m0_rbusy, bus.m1_rbusy}), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back: m1 strobes while m0 waits on a slow read.
    n = cyc;
    slow = 3;
    drive(0, 1'b1, 4'b0, 32'h600, 32'h0);
    push(0, 32'h600, 1'b1, 4'b0, 32'h0);
    step(1);
    drive(0, 1'b0, 4'b0, 32'h600, 32'h0);
    step(2);
    chk("b2b_m0_issue_cycle", 32'(last_issue_cyc), 32'(n + 2));
    step(1);
    drive(1, 1'b1, 4'b0, 32'h700, 32'h0);
    push(1, 32'h700, 1'b1, 4'b0, 32'h0);
    step(1);
    drive(1, 1'b0, 4'b0, 32'h700, 32'h0);
    chk("b2b_m1_rbusy", 32'(bus.m1_rbusy), 32'd1);
    step(2);
    slow = 0;
    chk("b2b_m0_done", 32'(bus.m0_rbusy), 32'd0);
    chk("b2b_m0_rdata", bus.m0_rdata, 32'h0600_F9FF);
    step(2);
    chk("b2b_m1_issue_cycle", 32'(last_issue_cyc), 32'(n + 8));
    step(1);
    chk("b2b_m1_done", 32'(bus.m1_rbusy), 32'd0);
    chk("b2b_m1_rdata", bus.m1_rdata, 32'h0700_F8FF);

    // Re-strobe while busy and on the completion cycle: both ignored.
    drive(0, 1'b1, 4'b0, 32'h800, 32'h0);
    push(0, 32'h800, 1'b1, 4'b0, 32'h0);
    step(1);
    drive(0, 1'b1, 4'b0, 32'h900, 32'h0);
    chk("viol_m0_rbusy", 32'(bus.m0_rbusy), 32'd1);
    step(1);
    drive(0, 1'b0, 4'b0, 32'h900, 32'h0);
    step(1);
    drive(0, 1'b1, 4'b0, 32'hA00, 32'h0);
    step(1);
    drive(0, 1'b0, 4'b0, 32'hA00, 32'h0);
    chk("viol_m0_done", 32'(bus.m0_rbusy), 32'd0);
    chk("viol_m0_rdata", bus.m0_rdata, 32'h0800_F7FF);
    step(2);
    chk("viol_no_new_req", 32'(bus.m0_rbusy | bus.m0_wbusy), 32'd0);

    // Reset pulse while m1 waits on a slow read.
    slow = 4;
    drive(1, 1'b1, 4'b0, 32'h1000, 32'h0);
    push(1, 32'h1000, 1'b1, 4'b0, 32'h0);
    step(1);
    drive(1, 1'b0, 4'b0, 32'h1000, 32'h0);
    step(3);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    chk("wrst_m0_rbusy", 32'(bus.m0_rbusy), 32'd0);
    chk("wrst_m1_rbusy", 32'(bus.m1_rbusy), 32'd0);
    chk("wrst_m1_wbusy", 32'(bus.m1_wbusy), 32'd0);
    chk("wrst_m0_rdata", bus.m0_rdata, 32'h0);
    chk("wrst_m1_rdata", bus.m1_rdata, 32'h0);
    chk("wrst_s_rstrb", 32'(bus.s_rstrb), 32'd0);
    chk("wrst_s_addr", bus.s_addr, 32'h0);
    step(6);
    chk("wrst_stays_idle", 32'(bus.m1_rbusy), 32'd0);
    run_vec(vecs[0]);

    step(2);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
